// File: rtl/rr_decode_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface rr_decode_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter_4.sv
// Round-robin arbiter for four requesters sharing one 2x4-decoded resource.
// Define TIMEOUT_EN to force a grant off after MAX_HOLD cycles; otherwise grants are held until released.
module rr_decode_arbiter_4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_decode_arbiter_4_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic       release_now;
  logic       force_off;

  // Reject configurations where the hold limit cannot be reached by the counter.
  if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
    $error("rr_decode_arbiter_4: MAX_HOLD out of range for CNT_W");
  end

  // Scan downwards so the candidate closest to ptr is the one that sticks.
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) begin
        winner = ptr + 2'(k);
      end
    end
  end

  assign release_now = bus.done || !bus.req[bus.gnt_idx];

`ifdef TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign force_off = (state == GRANT) && (hold_cnt == HOLD_LAST) && !release_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '1) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign force_off = 1'b0;
`endif

  // A forced release takes the normal release path; timeout only flags which one it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      bus.gnt       <= 4'b0000;
      bus.gnt_idx   <= 2'd0;
      bus.gnt_valid <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state         <= GRANT;
            bus.gnt_idx   <= winner;
            bus.gnt       <= 4'b0001 << winner;
            bus.gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (release_now || force_off) begin
            state         <= IDLE;
            bus.gnt       <= 4'b0000;
            bus.gnt_valid <= 1'b0;
            ptr           <= bus.gnt_idx + 2'd1;
            bus.timeout   <= force_off;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter_4.sv
// Randomized and directed bench for rr_decode_arbiter_4 with an in-bench behavioural model.
// Build with TIMEOUT_EN defined to exercise forced release (MAX_HOLD=4 in that build).
module tb_rr_decode_arbiter_4;

`ifdef TIMEOUT_EN
  localparam int MAX_HOLD   = 4;
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam int MAX_HOLD   = 15;
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef struct {
    int owner;
    int last;
    int ptr;
    int cycles;
    bit tmo;
  } model_t;

  logic   clk;
  logic   rst_n;
  bit     check_en;
  int     total;
  int     bad;
  model_t m;

  rr_decode_arbiter_4_if bus ();

  rr_decode_arbiter_4 #(
    .MAX_HOLD(MAX_HOLD),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t n;
    n.owner  = -1;
    n.last   = 0;
    n.ptr    = 0;
    n.cycles = 0;
    n.tmo    = 1'b0;
    return n;
  endfunction

  // owner = -1 means idle; cycles counts how many cycles the grant has been visible.
  function automatic model_t model_step(model_t cur, logic [3:0] r, logic d);
    model_t n = cur;
    bit normal;
    bit forced;
    n.tmo = 1'b0;
    if (cur.owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (n.owner < 0 && r[(cur.ptr + k) % 4]) begin
          n.owner  = (cur.ptr + k) % 4;
          n.last   = n.owner;
          n.cycles = 1;
        end
      end
    end else begin
      normal = d || !r[cur.owner];
      forced = TIMEOUT_ON && (cur.cycles >= MAX_HOLD) && !normal;
      if (normal || forced) begin
        n.ptr   = (cur.owner + 1) % 4;
        n.owner = -1;
        n.tmo   = forced;
      end else begin
        n.cycles = cur.cycles + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= model_reset();
    end else begin
      m <= model_step(m, bus.req, bus.done);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_gnt", int'(bus.gnt), (m.owner >= 0) ? (1 << m.owner) : 0);
      checkOutput("model_gnt_idx", int'(bus.gnt_idx), m.last);
      checkOutput("model_gnt_valid", int'(bus.gnt_valid), (m.owner >= 0) ? 1 : 0);
      checkOutput("model_timeout", int'(bus.timeout), int'(m.tmo));
    end
  end

  initial begin
    logic [3:0] r;
    logic       d;
    clk      = 1'b0;
    rst_n    = 1'b0;
    check_en = 1'b0;
    total    = 0;
    bad      = 0;
    bus.req  = 4'b1111;
    bus.done = 1'b0;

    @(negedge clk);
    checkOutput("reset_gnt", int'(bus.gnt), 0);
    checkOutput("reset_valid", int'(bus.gnt_valid), 0);
    checkOutput("reset_idx", int'(bus.gnt_idx), 0);
    checkOutput("reset_timeout", int'(bus.timeout), 0);
    check_en = 1'b1;

    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("first_gnt", int'(bus.gnt), 1);
    checkOutput("first_idx", int'(bus.gnt_idx), 0);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rot_idle_gnt", int'(bus.gnt), 0);
      checkOutput("rot_idle_idx_hold", int'(bus.gnt_idx), k - 1);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rot_gnt", int'(bus.gnt), 1 << (k % 4));
      checkOutput("rot_idx", int'(bus.gnt_idx), k % 4);
    end

    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_pre_idle", int'(bus.gnt), 0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_gnt", int'(bus.gnt), 4);
    checkOutput("single_idx", int'(bus.gnt_idx), 2);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_release", int'(bus.gnt), 0);
    checkOutput("single_idx_hold", int'(bus.gnt_idx), 2);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("search_from_3", int'(bus.gnt), 8);

    applyStimulus(4'b0011, 1'b1);
    checkOutput("wrap_idle", int'(bus.gnt), 0);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("wrap_gnt", int'(bus.gnt), 1);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("skip_idle", int'(bus.gnt), 0);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("skip_gnt", int'(bus.gnt), 8);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("skip_release", int'(bus.gnt), 0);

    applyStimulus(4'b0010, 1'b0);
    checkOutput("drop_gnt", int'(bus.gnt), 2);
    applyStimulus(4'b1110, 1'b0);
    checkOutput("drop_others_a", int'(bus.gnt), 2);
    applyStimulus(4'b1011, 1'b0);
    checkOutput("drop_others_b", int'(bus.gnt), 2);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("drop_release", int'(bus.gnt), 0);
    checkOutput("drop_timeout", int'(bus.timeout), 0);

    applyStimulus(4'b0100, 1'b0);
    checkOutput("hold_first", int'(bus.gnt), 4);
    if (TIMEOUT_ON) begin
      for (int i = 0; i < 3; i++) begin
        applyStimulus(4'b0100, 1'b0);
        checkOutput("hold_gnt", int'(bus.gnt), 4);
        checkOutput("hold_timeout", int'(bus.timeout), 0);
      end
      applyStimulus(4'b0100, 1'b0);
      checkOutput("forced_gnt", int'(bus.gnt), 0);
      checkOutput("forced_timeout", int'(bus.timeout), 1);
      applyStimulus(4'b0100, 1'b0);
      checkOutput("regrant_gnt", int'(bus.gnt), 4);
      checkOutput("regrant_timeout", int'(bus.timeout), 0);
    end else begin
      for (int i = 0; i < 100; i++) begin
        applyStimulus(4'b0100, 1'b0);
        checkOutput("hold_gnt", int'(bus.gnt), 4);
        checkOutput("hold_timeout", int'(bus.timeout), 0);
      end
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("hold_release", int'(bus.gnt), 0);

    applyStimulus(4'b1000, 1'b0);
    checkOutput("pre_reset_gnt", int'(bus.gnt), 8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_gnt", int'(bus.gnt), 0);
    checkOutput("async_reset_valid", int'(bus.gnt_valid), 0);
    checkOutput("async_reset_idx", int'(bus.gnt_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("post_reset_gnt", int'(bus.gnt), 1);

    r = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = 4'($urandom_range(0, 15));
      end
      d = ($urandom_range(0, 7) == 0);
      applyStimulus(r, d);
      if (i % 997 == 500) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
